// File: rtl/pgm_pkg.sv
// pgm_pkg: shared encodings for the PGM run-control scheduler.
// Holds state codes, register map, op and header codes.
package pgm_pkg;

  localparam int WORD_W = 134;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3
  } state_e;

  localparam logic [31:0] ADDR_CTRL   = 32'h0002_0000;
  localparam logic [31:0] ADDR_TARGET = 32'h0002_0001;
  localparam logic [31:0] ADDR_SENT   = 32'h0002_0002;
  localparam logic [31:0] ADDR_STATUS = 32'h0002_0003;

  localparam logic [2:0] OP_WR = 3'b010;
  localparam logic [2:0] OP_RD = 3'b001;

  localparam logic [1:0] HDR_SOP = 2'b01;
  localparam logic [1:0] HDR_MID = 2'b11;
  localparam logic [1:0] HDR_EOP = 2'b10;

  localparam logic [3:0]  RSP_RD  = 4'b1011;
  localparam logic [31:0] RD_MISS = 32'hffff_ffff;

  typedef struct packed {
    logic        ctrl;
    logic        target;
    logic [31:0] data;
  } cfg_wr_t;

  typedef struct packed {
    logic [31:0] target;
    logic [31:0] sent;
    logic [31:0] status;
  } cfg_rd_t;

endpackage

// File: rtl/pgm_sched_if.sv
// pgm_sched_if: 134-bit configuration chain through the scheduler.
// slave = scheduler side, master = upstream/downstream environment.
interface pgm_sched_if;
  import pgm_pkg::*;

  logic [WORD_W-1:0] cin_sched_data;
  logic              cin_sched_data_wr;
  logic              cout_sched_ready;
  logic [WORD_W-1:0] cout_sched_data;
  logic              cout_sched_data_wr;
  logic              cin_sched_ready;

  modport slave (
    input  cin_sched_data,
    input  cin_sched_data_wr,
    input  cin_sched_ready,
    output cout_sched_ready,
    output cout_sched_data,
    output cout_sched_data_wr
  );

  modport master (
    output cin_sched_data,
    output cin_sched_data_wr,
    output cin_sched_ready,
    input  cout_sched_ready,
    input  cout_sched_data,
    input  cout_sched_data_wr
  );

endinterface

// File: rtl/pgm_cfg_if.sv
// pgm_cfg_if: config-chain decode, register read mux, 1-cycle forward.
// Read hits are rewritten into responses; everything else passes as-is.
import pgm_pkg::*;

module pgm_cfg_if #(
  parameter logic [7:0] LMID = 8'd62
) (
  input  logic       clk,
  input  logic       rst,
  pgm_sched_if.slave cfg,
  input  cfg_rd_t    rd_i,
  output cfg_wr_t    wr_o
);

  logic [WORD_W-1:0] cout_data_d, cout_data_q;
  logic              cout_wr_d, cout_wr_q;
  logic              hit, is_wr, is_rd;
  logic [31:0]       addr, rdata;

  assign cfg.cout_sched_ready   = cfg.cin_sched_ready;
  assign cfg.cout_sched_data    = cout_data_q;
  assign cfg.cout_sched_data_wr = cout_wr_q;

  // decode a request word addressed to this block
  always_comb begin
    hit = cfg.cin_sched_data_wr
        & cfg.cin_sched_ready
        & (cfg.cin_sched_data[133:132] == HDR_SOP)
        & (cfg.cin_sched_data[103:96] == LMID);
    addr  = cfg.cin_sched_data[95:64];
    is_wr = hit & (cfg.cin_sched_data[126:124] == OP_WR);
    is_rd = hit & (cfg.cin_sched_data[126:124] == OP_RD);
  end

  // register read mux, unknown addresses read all-ones
  always_comb begin
    rdata = RD_MISS;
    unique case (addr)
      ADDR_TARGET: rdata = rd_i.target;
      ADDR_SENT:   rdata = rd_i.sent;
      ADDR_STATUS: rdata = rd_i.status;
      default:     rdata = RD_MISS;
    endcase
  end

  // write strobes towards the run-control logic
  always_comb begin
    wr_o        = '0;
    wr_o.data   = cfg.cin_sched_data[31:0];
    wr_o.ctrl   = is_wr & (addr == ADDR_CTRL);
    wr_o.target = is_wr & (addr == ADDR_TARGET);
  end

  // next forwarded word, read hits become responses
  always_comb begin
    cout_wr_d   = cfg.cin_sched_data_wr;
    cout_data_d = cfg.cin_sched_data;
    if (is_rd) begin
      cout_data_d[127:124] = RSP_RD;
      cout_data_d[31:0]    = rdata;
    end
  end

  // one-cycle pass-through register
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_data_q <= '0;
      cout_wr_q   <= 1'b0;
    end else begin
      cout_data_q <= cout_data_d;
      cout_wr_q   <= cout_wr_d;
    end
  end

endmodule

// File: rtl/pgm_sched.sv
// pgm_sched: run-control FSM and sent-packet counter for the PGM read path.
// Registers are reached through the config chain via pgm_cfg_if.
import pgm_pkg::*;

module pgm_sched #(
  parameter logic [7:0] LMID  = 8'd62,
  parameter int         CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pgm_loaded,
  input  logic       mon_data_wr,
  input  logic [1:0] mon_data_hdr,
  output logic       pgm_bypass_flag,
  output logic       pgm_sent_start_flag,
  output logic       pgm_sent_finish_flag,
  pgm_sched_if.slave cfg
);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] target_d, target_q;
  logic [CNT_W-1:0] sent_d, sent_q;
  logic             err_d, err_q;
  logic             stop_d, stop_q;

  cfg_wr_t wr;
  cfg_rd_t rd;

  logic start_w, stop_w, clr_w;
  logic eop, tgt_hit;
  logic bypass, start, finish;

  pgm_cfg_if #(.LMID(LMID)) u_cfg (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg),
    .rd_i (rd),
    .wr_o (wr)
  );

  assign start_w = wr.ctrl & wr.data[0];
  assign stop_w  = wr.ctrl & wr.data[1];
  assign clr_w   = wr.ctrl & wr.data[2];
  assign eop     = mon_data_wr & (mon_data_hdr == HDR_EOP);

  // finish one eop early so the engine stops right after the target-th
  assign tgt_hit = (target_q != '0)
                 & (sent_q >= target_q - CNT_W'(1));

  assign pgm_bypass_flag      = bypass;
  assign pgm_sent_start_flag  = start;
  assign pgm_sent_finish_flag = finish;

  // register read-back values
  always_comb begin
    rd        = '0;
    rd.target = 32'(target_q);
    rd.sent   = 32'(sent_q);
    rd.status = {27'd0, pgm_loaded, err_q, state_q};
  end

  // flags driven to the read engine, decoded from state
  always_comb begin
    bypass = 1'b0;
    start  = 1'b0;
    finish = 1'b0;
    unique case (state_q)
      ST_IDLE:   bypass = 1'b1;
      ST_LAUNCH: start  = 1'b1;
      ST_RUN:    finish = tgt_hit | stop_q;
      ST_DONE:   finish = 1'b1;
      default:   bypass = 1'b1;
    endcase
  end

  // next state, counter and control registers
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sent_d   = sent_q;
    err_d    = err_q;
    stop_d   = stop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr.target) target_d = CNT_W'(wr.data);
        if (clr_w) begin
          sent_d = '0;
          err_d  = 1'b0;
          stop_d = 1'b0;
        end
        if (start_w) begin
          if (pgm_loaded) state_d = ST_LAUNCH;
          else            err_d   = 1'b1;
        end
      end
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (stop_w) stop_d = 1'b1;
        if (eop) begin
          sent_d = sent_q + CNT_W'(1);
          if (finish) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (clr_w) begin
          sent_d  = '0;
          err_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and register flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      sent_q   <= '0;
      err_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sent_q   <= sent_d;
      err_q    <= err_d;
      stop_q   <= stop_d;
    end
  end

endmodule

// File: tb/tb_pgm_sched.sv
// tb_pgm_sched: randomized scenario bench for pgm_sched.
// Expectations come from packet-count arithmetic, not state tracking.
module tb_pgm_sched;
  import pgm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       pgm_loaded;
  logic       mon_data_wr;
  logic [1:0] mon_data_hdr;
  logic       bypass, start, finish;
  int         total = 0;
  int         bad = 0;

  pgm_sched_if cfg();

  pgm_sched #(.LMID(8'd62), .CNT_W(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pgm_loaded           (pgm_loaded),
    .mon_data_wr          (mon_data_wr),
    .mon_data_hdr         (mon_data_hdr),
    .pgm_bypass_flag      (bypass),
    .pgm_sent_start_flag  (start),
    .pgm_sent_finish_flag (finish),
    .cfg                  (cfg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] mk(input logic [2:0] op,
      input logic [7:0] mid, input logic [31:0] a,
      input logic [31:0] d);
    logic [159:0] r;
    logic [133:0] w;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    w = r[133:0];
    w[133:132] = HDR_SOP;
    w[126:124] = op;
    w[103:96]  = mid;
    w[95:64]   = a;
    w[31:0]    = d;
    return w;
  endfunction

  task automatic send(input logic [133:0] w, input logic rdy,
      output logic [133:0] o, output logic owr);
    cfg.cin_sched_data    = w;
    cfg.cin_sched_data_wr = 1'b1;
    cfg.cin_sched_ready   = rdy;
    tick();
    o   = cfg.cout_sched_data;
    owr = cfg.cout_sched_data_wr;
    cfg.cin_sched_data_wr = 1'b0;
    cfg.cin_sched_ready   = 1'b1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    logic [133:0] o;
    logic         owr;
    send(mk(OP_WR, 8'd62, a, d), 1'b1, o, owr);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
    logic [133:0] o;
    logic         owr;
    send(mk(OP_RD, 8'd62, a, $urandom), 1'b1, o, owr);
    v = o[31:0];
  endtask

  task automatic mon(input logic [1:0] h, input logic w);
    mon_data_hdr = h;
    mon_data_wr  = w;
    tick();
    mon_data_wr  = 1'b0;
  endtask

  task automatic noise();
    repeat ($urandom_range(0, 2)) begin
      case ($urandom_range(0, 2))
        0:       mon(HDR_SOP, 1'b1);
        1:       mon(HDR_MID, 1'b1);
        default: mon(HDR_EOP, 1'b0);
      endcase
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    pgm_loaded = 1'b1;
    mon_data_wr = 1'b0;
    mon_data_hdr = 2'b00;
    cfg.cin_sched_data = '0;
    cfg.cin_sched_data_wr = 1'b0;
    cfg.cin_sched_ready = 1'b1;
    repeat (3) tick();
    total++;
    if ({bypass, start, finish} !== 3'b100) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=100",
               {bypass, start, finish});
    end
    total++;
    if ({cfg.cout_sched_data_wr, cfg.cout_sched_data} !== 135'd0) begin
      bad++;
      $display("FAIL reset_cout got=%h exp=0", cfg.cout_sched_data);
    end
    rst = 1'b0;
    tick();
    rd_reg(ADDR_STATUS, v);
    total++;
    if (v !== 32'h10) begin
      bad++;
      $display("FAIL reset_status got=%h exp=00000010", v);
    end
    rd_reg(ADDR_SENT, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL reset_sent got=%h exp=0", v);
    end
  endtask

  task automatic test_target_run();
    int          t;
    logic [31:0] v;
    for (int it = 0; it < 4; it++) begin
      t = $urandom_range(1, 6);
      pgm_loaded = 1'b1;
      wr_reg(ADDR_TARGET, t);
      rd_reg(ADDR_TARGET, v);
      total++;
      if (v !== 32'(t)) begin
        bad++;
        $display("FAIL target_rd got=%0d exp=%0d", v, t);
      end
      wr_reg(ADDR_CTRL, 32'h1);
      total++;
      if ({bypass, start, finish} !== 3'b010) begin
        bad++;
        $display("FAIL launch_flags got=%b exp=010",
                 {bypass, start, finish});
      end
      tick();
      total++;
      if (start !== 1'b0) begin
        bad++;
        $display("FAIL start_width got=%b exp=0", start);
      end
      for (int k = 0; k < t; k++) begin
        noise();
        total++;
        if (finish !== (k >= t - 1)) begin
          bad++;
          $display("FAIL finish_at_eop%0d got=%b exp=%b",
                   k, finish, (k >= t - 1));
        end
        mon(HDR_EOP, 1'b1);
      end
      repeat ($urandom_range(0, 2)) mon(HDR_EOP, 1'b1);
      rd_reg(ADDR_SENT, v);
      total++;
      if (v !== 32'(t)) begin
        bad++;
        $display("FAIL sent_done got=%0d exp=%0d", v, t);
      end
      rd_reg(ADDR_STATUS, v);
      total++;
      if (v !== 32'h13 || finish !== 1'b1 || bypass !== 1'b0) begin
        bad++;
        $display("FAIL done_status got=%h/%b%b exp=13/10",
                 v, finish, bypass);
      end
      wr_reg(ADDR_CTRL, 32'h4);
      rd_reg(ADDR_STATUS, v);
      total++;
      if (v !== 32'h10 || {bypass, start, finish} !== 3'b100) begin
        bad++;
        $display("FAIL clear_status got=%h/%b exp=10/100",
                 v, {bypass, start, finish});
      end
      rd_reg(ADDR_SENT, v);
      total++;
      if (v !== 32'h0) begin
        bad++;
        $display("FAIL clear_sent got=%0d exp=0", v);
      end
    end
  endtask

  task automatic test_stop();
    int          n;
    logic        coinc;
    logic [31:0] v;
    for (int it = 0; it < 3; it++) begin
      pgm_loaded = 1'b1;
      wr_reg(ADDR_TARGET, 32'h0);
      wr_reg(ADDR_CTRL, ($urandom_range(0, 1) != 0) ? 32'h3 : 32'h1);
      total++;
      if (start !== 1'b1) begin
        bad++;
        $display("FAIL stop_launch got=%b exp=1", start);
      end
      tick();
      n = $urandom_range(3, 7);
      for (int k = 0; k < n; k++) begin
        noise();
        if (k == 1) pgm_loaded = 1'b0;
        total++;
        if (finish !== 1'b0) begin
          bad++;
          $display("FAIL cont_finish%0d got=%b exp=0", k, finish);
        end
        mon(HDR_EOP, 1'b1);
      end
      coinc = 1'($urandom_range(0, 1));
      total++;
      if (finish !== 1'b0) begin
        bad++;
        $display("FAIL pre_stop_finish got=%b exp=0", finish);
      end
      if (coinc) begin
        mon_data_hdr = HDR_EOP;
        mon_data_wr  = 1'b1;
        n++;
      end
      wr_reg(ADDR_CTRL, ($urandom_range(0, 1) != 0) ? 32'h3 : 32'h2);
      mon_data_wr = 1'b0;
      total++;
      if (finish !== 1'b1) begin
        bad++;
        $display("FAIL stop_finish got=%b exp=1", finish);
      end
      rd_reg(ADDR_STATUS, v);
      total++;
      if (v !== {27'd0, pgm_loaded, 1'b0, 3'd2}) begin
        bad++;
        $display("FAIL stop_run_status got=%h exp=%h",
                 v, {27'd0, pgm_loaded, 1'b0, 3'd2});
      end
      mon(HDR_EOP, 1'b1);
      n++;
      wr_reg(ADDR_CTRL, 32'h1);
      total++;
      if (start !== 1'b0 || finish !== 1'b1) begin
        bad++;
        $display("FAIL done_restart got=%b%b exp=01", start, finish);
      end
      rd_reg(ADDR_SENT, v);
      total++;
      if (v !== 32'(n)) begin
        bad++;
        $display("FAIL stop_sent got=%0d exp=%0d", v, n);
      end
      rd_reg(ADDR_STATUS, v);
      total++;
      if (v[2:0] !== 3'd3) begin
        bad++;
        $display("FAIL stop_done_state got=%0d exp=3", v[2:0]);
      end
      wr_reg(ADDR_CTRL, 32'h4);
      rd_reg(ADDR_STATUS, v);
      total++;
      if (v !== {27'd0, pgm_loaded, 4'd0}) begin
        bad++;
        $display("FAIL stop_clear got=%h exp=%h",
                 v, {27'd0, pgm_loaded, 4'd0});
      end
    end
    pgm_loaded = 1'b1;
  endtask

  task automatic test_err();
    logic [31:0] v;
    pgm_loaded = 1'b0;
    wr_reg(ADDR_CTRL, 32'h1);
    total++;
    if (start !== 1'b0 || bypass !== 1'b1) begin
      bad++;
      $display("FAIL err_nostart got=%b%b exp=01", start, bypass);
    end
    rd_reg(ADDR_STATUS, v);
    total++;
    if (v !== 32'h8) begin
      bad++;
      $display("FAIL err_status got=%h exp=00000008", v);
    end
    wr_reg(ADDR_CTRL, 32'h4);
    rd_reg(ADDR_STATUS, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL err_clear got=%h exp=0", v);
    end
    pgm_loaded = 1'b1;
  endtask

  task automatic test_cfg_chain();
    logic [133:0] w, e, o;
    logic         owr;
    logic [31:0]  v;
    w = mk(OP_RD, 8'd61, ADDR_STATUS, $urandom);
    send(w, 1'b1, o, owr);
    total++;
    if (o !== w || owr !== 1'b1) begin
      bad++;
      $display("FAIL other_mid got=%h exp=%h", o, w);
    end
    w = mk(OP_RD, 8'd62, 32'h0002_0099, $urandom);
    e = w;
    e[127:124] = RSP_RD;
    e[31:0] = 32'hffff_ffff;
    send(w, 1'b1, o, owr);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL unknown_rd got=%h exp=%h", o, e);
    end
    w = mk(OP_RD, 8'd62, ADDR_STATUS, $urandom);
    send(w, 1'b0, o, owr);
    total++;
    if (o !== w) begin
      bad++;
      $display("FAIL not_ready got=%h exp=%h", o, w);
    end
    w = mk(OP_WR, 8'd62, ADDR_TARGET, 32'd5);
    send(w, 1'b1, o, owr);
    total++;
    if (o !== w) begin
      bad++;
      $display("FAIL wr_forward got=%h exp=%h", o, w);
    end
    w = mk(OP_WR, 8'd61, ADDR_TARGET, 32'd9);
    send(w, 1'b1, o, owr);
    w = mk(OP_WR, 8'd62, ADDR_TARGET, 32'd7);
    w[133:132] = HDR_MID;
    send(w, 1'b1, o, owr);
    rd_reg(ADDR_TARGET, v);
    total++;
    if (v !== 32'd5) begin
      bad++;
      $display("FAIL target_decode got=%0d exp=5", v);
    end
    tick();
    total++;
    if (cfg.cout_sched_data_wr !== 1'b0) begin
      bad++;
      $display("FAIL idle_wr got=%b exp=0", cfg.cout_sched_data_wr);
    end
    cfg.cin_sched_ready = 1'b0;
    #1;
    total++;
    if (cfg.cout_sched_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_pass got=%b exp=0", cfg.cout_sched_ready);
    end
    cfg.cin_sched_ready = 1'b1;
    wr_reg(ADDR_TARGET, 32'h0);
  endtask

  task automatic test_run_wr_and_reset();
    logic [31:0] v;
    pgm_loaded = 1'b1;
    wr_reg(ADDR_TARGET, 32'd4);
    wr_reg(ADDR_CTRL, 32'h1);
    tick();
    wr_reg(ADDR_TARGET, 32'd9);
    rd_reg(ADDR_TARGET, v);
    total++;
    if (v !== 32'd4) begin
      bad++;
      $display("FAIL run_target_wr got=%0d exp=4", v);
    end
    repeat (3) mon(HDR_EOP, 1'b1);
    total++;
    if (finish !== 1'b1 || bypass !== 1'b0) begin
      bad++;
      $display("FAIL pre_rst got=%b%b exp=10", finish, bypass);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bypass, start, finish} !== 3'b100) begin
      bad++;
      $display("FAIL rst_run_flags got=%b exp=100",
               {bypass, start, finish});
    end
    rd_reg(ADDR_SENT, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL rst_run_sent got=%0d exp=0", v);
    end
    rd_reg(ADDR_TARGET, v);
    total++;
    if (v !== 32'd0) begin
      bad++;
      $display("FAIL rst_run_target got=%0d exp=0", v);
    end
  endtask

  initial begin
    test_reset();
    test_target_run();
    test_stop();
    test_err();
    test_cfg_chain();
    test_run_wr_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
